// File: rtl/blake2_io_tx.sv
// Byte-serial transmitter feeding a BLAKE2 receiver: config, then 64-byte blocks.
// Define BLAKE2_IO_TX_PAD_EN to zero-fill a block once the message runs out.
module blake2_io_tx #(
    parameter logic [1:0] CMD_CONF  = 2'd0,
    parameter logic [1:0] CMD_START = 2'd1,
    parameter logic [1:0] CMD_DATA  = 2'd2,
    parameter logic [1:0] CMD_LAST  = 2'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_i,
    input  logic [5:0]  kk_i,
    input  logic [5:0]  nn_i,
    input  logic [63:0] ll_i,
    input  logic        in_valid_i,
    input  logic [7:0]  in_data_i,
    output logic        in_ready_o,
    output logic        valid_o,
    output logic [1:0]  cmd_o,
    output logic [7:0]  data_o,
    output logic        busy_o,
    output logic        done_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONF = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

`ifdef BLAKE2_IO_TX_PAD_EN
    localparam logic PAD = 1'b1;
`else
    localparam logic PAD = 1'b0;
`endif

    logic [1:0]  state;
    logic [63:0] rem;
    logic [5:0]  idx;
    logic [5:0]  nn_q;
    logic [3:0]  cnt;
    logic        first_blk;
    logic        last_q;

    logic        rem_nz;
    logic        take;
    logic        pad_byte;
    logic        send;
    logic        is_last;
    logic [3:0]  bsel;
    logic [7:0]  conf_byte;
    logic [1:0]  data_cmd;

    assign rem_nz   = |rem;
    assign take     = (state == S_DATA) && (rem_nz || !PAD) && in_valid_i;
    assign pad_byte = (state == S_DATA) && !rem_nz && PAD;
    assign send     = take || pad_byte;
    // The last-block decision is made once, at the head of each block.
    assign is_last  = (idx == 6'd0) ? (rem <= 64'd64) : last_q;
    assign bsel     = cnt - 4'd2;

    assign in_ready_o = take && !reset;
    assign busy_o     = (state != S_IDLE);

    always_comb begin
        conf_byte = rem[{bsel[2:0], 3'b000} +: 8];
        if (cnt == 4'd1) begin
            conf_byte = {2'b00, nn_q};
        end
    end

    always_comb begin
        data_cmd = CMD_DATA;
        unique case (1'b1)
            (first_blk && idx == 6'd0): data_cmd = CMD_START;
            (!(first_blk && idx == 6'd0) && is_last): data_cmd = CMD_LAST;
            default: data_cmd = CMD_DATA;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            valid_o   <= 1'b0;
            cmd_o     <= CMD_CONF;
            data_o    <= 8'h00;
            done_o    <= 1'b0;
            idx       <= 6'd0;
            rem       <= 64'd0;
            cnt       <= 4'd0;
            nn_q      <= 6'd0;
            first_blk <= 1'b0;
            last_q    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            done_o  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        rem     <= ll_i;
                        nn_q    <= nn_i;
                        valid_o <= 1'b1;
                        cmd_o   <= CMD_CONF;
                        data_o  <= {2'b00, kk_i};
                        cnt     <= 4'd1;
                        state   <= S_CONF;
                    end
                end
                S_CONF: begin
                    valid_o <= 1'b1;
                    cmd_o   <= CMD_CONF;
                    data_o  <= conf_byte;
                    cnt     <= cnt + 4'd1;
                    if (cnt == 4'd9) begin
                        idx       <= 6'd0;
                        first_blk <= 1'b1;
                        state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (send) begin
                        valid_o <= 1'b1;
                        cmd_o   <= data_cmd;
                        data_o  <= take ? in_data_i : 8'h00;
                        idx     <= idx + 6'd1;
                        if (idx == 6'd0) begin
                            last_q <= is_last;
                        end
                        if (take && rem_nz) begin
                            rem <= rem - 64'd1;
                        end
                        if (idx == 6'd63) begin
                            first_blk <= 1'b0;
                            if (is_last) begin
                                state <= S_DONE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    done_o <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blake2_io_tx.sv
// Randomized scoreboard bench for blake2_io_tx; expected link bytes come
// from a block-level model of the message framing.
module tb_blake2_io_tx;

`ifdef BLAKE2_IO_TX_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    localparam logic [1:0] C_CONF  = 2'd0;
    localparam logic [1:0] C_START = 2'd1;
    localparam logic [1:0] C_DATA  = 2'd2;
    localparam logic [1:0] C_LAST  = 2'd3;

    typedef struct {
        bit         conf;
        logic [1:0] cmd;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [5:0]  kk_i = '0;
    logic [5:0]  nn_i = '0;
    logic [63:0] ll_i = '0;
    logic        in_valid_i = 1'b0;
    logic [7:0]  in_data_i = '0;
    logic        in_ready_o;
    logic        valid_o;
    logic [1:0]  cmd_o;
    logic [7:0]  data_o;
    logic        busy_o;
    logic        done_o;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   msg_pops = 0;
    int   last_cyc = 0;
    int   done_cyc = 0;
    bit   pend_done = 0;
    bit   done_seen = 0;
    exp_t q[$];

    blake2_io_tx dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_i),
        .kk_i       (kk_i),
        .nn_i       (nn_i),
        .ll_i       (ll_i),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data_i),
        .in_ready_o (in_ready_o),
        .valid_o    (valid_o),
        .cmd_o      (cmd_o),
        .data_o     (data_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every link byte.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (valid_o) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_byte: got cmd=%0d data=%02h want none",
                             cmd_o, data_o);
                end else begin
                    e = q.pop_front();
                    if (cmd_o !== e.cmd || data_o !== e.data) begin
                        errors++;
                        $display("FAIL link_byte[%0d]: got cmd=%0d data=%02h want cmd=%0d data=%02h",
                                 msg_pops, cmd_o, data_o, e.cmd, e.data);
                    end
                    if (e.conf && msg_pops > 0) begin
                        chk("conf_contiguous", 64'(cyc), 64'(last_cyc + 1));
                    end
                    last_cyc = cyc;
                    msg_pops++;
                    if (q.size() == 0) begin
                        pend_done = 1;
                        done_cyc = cyc + 1;
                    end
                end
            end
            if (pend_done && cyc == done_cyc) begin
                chk("done_timing", 64'(done_o), 64'd1);
                pend_done = 0;
            end else if (done_o) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got 1 want 0");
            end
            if (done_o) done_seen = 1;
        end
    end

    // Caller must be between a negedge and the following posedge.
    task automatic run_msg(input int kk, input int nn, input int ll,
                           input int mode, input bit hold,
                           input int abort_at, input bit fixed);
        logic [7:0]  host[$];
        logic [7:0]  fx[3];
        logic [63:0] ll64;
        logic [5:0]  kk6;
        logic [5:0]  nn6;
        int          nblk;
        int          n;
        int          ptr;
        int          budget;
        bit          cons;
        bit          fin;
        bit          v;
        logic [1:0]  c;
        logic [7:0]  d;
        fx = '{8'hAA, 8'hBB, 8'hCC};
        ll64 = 64'(ll);
        kk6 = kk[5:0];
        nn6 = nn[5:0];
        nblk = (ll == 0) ? 1 : (ll + 63) / 64;
        n = PAD ? ll : 64 * nblk;
        for (int i = 0; i < n; i++)
            host.push_back((fixed && i < 3) ? fx[i] : 8'($urandom));
        q.push_back('{1'b1, C_CONF, {2'b00, kk6}});
        q.push_back('{1'b1, C_CONF, {2'b00, nn6}});
        for (int j = 0; j < 8; j++)
            q.push_back('{1'b1, C_CONF, ll64[8*j +: 8]});
        ptr = 0;
        for (int b = 0; b < nblk; b++) begin
            for (int i = 0; i < 64; i++) begin
                if (b == 0 && i == 0) c = C_START;
                else if (b == nblk - 1) c = C_LAST;
                else c = C_DATA;
                d = (ptr < n) ? host[ptr] : 8'h00;
                ptr++;
                q.push_back('{1'b0, c, d});
            end
        end
        msg_pops = 0;
        done_seen = 0;
        pend_done = 0;
        ptr = 0;
        fin = 0;
        budget = 40 + nblk * 64 * 5;
        start_i = 1'b1;
        kk_i = kk6;
        nn_i = nn6;
        ll_i = ll64;
        for (int t = 0; t < budget; t++) begin
            case (mode)
                0: v = 1'b1;
                1: v = (t % 2 == 0);
                default: v = 1'($urandom);
            endcase
            in_valid_i = v;
            in_data_i = (ptr < n) ? host[ptr] : 8'($urandom);
            #1;
            cons = in_ready_o;
            if (in_ready_o && !in_valid_i) begin
                checks++;
                errors++;
                $display("FAIL ready_without_valid: got 1 want 0");
            end
            @(posedge clk);
            if (cons) ptr++;
            @(negedge clk);
            #2;
            if (!hold) start_i = 1'b0;
            if (done_seen) begin
                fin = 1;
                break;
            end
            if (abort_at > 0 && msg_pops == abort_at) begin
                reset = 1'b1;
                start_i = 1'b0;
                in_valid_i = 1'b0;
                q.delete();
                pend_done = 0;
                @(posedge clk);
                @(negedge clk);
                #1;
                chk("abort_valid", 64'(valid_o), 64'd0);
                chk("abort_busy", 64'(busy_o), 64'd0);
                chk("abort_done", 64'(done_o), 64'd0);
                reset = 1'b0;
                return;
            end
        end
        start_i = 1'b0;
        in_valid_i = 1'b0;
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL timeout: got no done_o want done within %0d cycles", budget);
            q.delete();
            pend_done = 0;
        end
        repeat (4) @(negedge clk);
        #2;
        chk("host_consumed", 64'(ptr), 64'(n));
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("queue_drained", 64'(q.size()), 64'd0);
    endtask

    initial begin
        reset = 1'b1;
        in_valid_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_cmd", 64'(cmd_o), 64'(C_CONF));
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_done", 64'(done_o), 64'd0);
        chk("rst_ready", 64'(in_ready_o), 64'd0);
        reset = 1'b0;
        in_valid_i = 1'b0;
        #1;
        run_msg(0, 32, 3, 0, 1'b0, 0, 1'b1);
        run_msg(0, 63, 0, 0, 1'b0, 0, 1'b0);
        run_msg(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                130, 1, 1'b0, 0, 1'b0);
        run_msg(5, 32, 200, 0, 1'b0, 30, 1'b0);
        run_msg(1, 16, 1, 2, 1'b0, 0, 1'b0);
        run_msg(0, 32, 64, 0, 1'b1, 0, 1'b0);
        for (int k = 0; k < 4; k++)
            run_msg(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 200)), 2, 1'b0, 0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
